// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with memory handshake and retired-instruction counter.
// Optional MCTRL_ILLEGAL_TRAP_EN: illegal instructions park the FSM in TRAP with a sticky illegal flag.
module multicycle_ctrl #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       instr_op,
  input  logic [5:0]       instr_func,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             ir_wr,
  output logic             i_or_d,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             ext_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctr,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t cur, nxt;
  logic   rdy;
  logic   pc_wr_c, ir_wr_c;

  assign state = cur;
  assign rdy   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  // PC/IR writes are suppressed while reset is held, even though FETCH decodes them.
  assign pc_wr = pc_wr_c & rst_n;
  assign ir_wr = ir_wr_c & rst_n;

  always_comb begin
    nxt        = cur;
    pc_wr_c    = 1'b0;
    ir_wr_c    = 1'b0;
    pc_src     = 2'b00;
    i_or_d     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ext_op     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctr    = 3'b000;
    instr_done = 1'b0;
    case (cur)
      FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        if (rdy) begin
          ir_wr_c = 1'b1;
          pc_wr_c = 1'b1;
          nxt     = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (instr_op)
          OP_J: begin
            pc_wr_c    = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
            nxt        = FETCH;
          end
          OP_R, OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ: nxt = EXEC;
          default: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
            nxt = TRAP;
`else
            instr_done = 1'b1;
            nxt        = FETCH;
`endif
          end
        endcase
      end
      EXEC: begin
        alu_src_a = 1'b1;
        case (instr_op)
          OP_R: begin
            nxt = WB;
            case (instr_func)
              6'b100000: alu_ctr = 3'b001;
              6'b100010: alu_ctr = 3'b101;
              6'b100011: alu_ctr = 3'b100;
              6'b101010: alu_ctr = 3'b111;
              6'b101011: alu_ctr = 3'b110;
              default: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                nxt = TRAP;
`else
                instr_done = 1'b1;
                nxt        = FETCH;
`endif
              end
            endcase
          end
          OP_ORI: begin
            alu_src_b = 2'b10;
            alu_ctr   = 3'b010;
            nxt       = WB;
          end
          OP_ADDIU: begin
            alu_src_b = 2'b10;
            ext_op    = 1'b1;
            nxt       = WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 2'b10;
            ext_op    = 1'b1;
            nxt       = MEM;
          end
          OP_BEQ: begin
            alu_ctr    = 3'b100;
            pc_src     = 2'b01;
            pc_wr_c    = alu_zero;
            instr_done = 1'b1;
            nxt        = FETCH;
          end
          default: nxt = FETCH;
        endcase
      end
      MEM: begin
        i_or_d = 1'b1;
        if (instr_op == OP_LW) mem_rd = 1'b1;
        else                   mem_wr = 1'b1;
        if (rdy) begin
          if (instr_op == OP_LW) begin
            nxt = WB;
          end else begin
            instr_done = 1'b1;
            nxt        = FETCH;
          end
        end
      end
      WB: begin
        reg_wr     = 1'b1;
        reg_dst    = (instr_op == OP_R);
        mem_to_reg = (instr_op == OP_LW);
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      TRAP:    nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= FETCH;
      retired_cnt <= '0;
    end else begin
      cur <= nxt;
      if (instr_done) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

`ifdef MCTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             illegal <= 1'b0;
    else if (nxt == TRAP)   illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: handshake DUT (CNT_W=32) and single-cycle-memory DUT (CNT_W=2).
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst0_n;
  logic [5:0] op, func;
  logic       zero, rdy;

  logic       m_pc_wr, m_ir_wr, m_i_or_d, m_mem_rd, m_mem_wr, m_reg_wr, m_reg_dst;
  logic       m_mem_to_reg, m_ext_op, m_alu_src_a, m_instr_done, m_illegal;
  logic [1:0] m_pc_src, m_alu_src_b;
  logic [2:0] m_alu_ctr, m_state;
  logic [31:0] m_cnt;

  logic       z_pc_wr, z_ir_wr, z_i_or_d, z_mem_rd, z_mem_wr, z_reg_wr, z_reg_dst;
  logic       z_mem_to_reg, z_ext_op, z_alu_src_a, z_instr_done, z_illegal;
  logic [1:0] z_pc_src, z_alu_src_b;
  logic [2:0] z_alu_ctr, z_state;
  logic [1:0] z_cnt;

  multicycle_ctrl #(.MEM_HANDSHAKE(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_op(op), .instr_func(func), .alu_zero(zero),
    .mem_ready(rdy), .pc_wr(m_pc_wr), .pc_src(m_pc_src), .ir_wr(m_ir_wr),
    .i_or_d(m_i_or_d), .mem_rd(m_mem_rd), .mem_wr(m_mem_wr), .reg_wr(m_reg_wr),
    .reg_dst(m_reg_dst), .mem_to_reg(m_mem_to_reg), .ext_op(m_ext_op),
    .alu_src_a(m_alu_src_a), .alu_src_b(m_alu_src_b), .alu_ctr(m_alu_ctr),
    .state(m_state), .instr_done(m_instr_done), .illegal(m_illegal), .retired_cnt(m_cnt)
  );

  // mem_ready held low: this instance must ignore it.
  multicycle_ctrl #(.MEM_HANDSHAKE(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst0_n), .instr_op(op), .instr_func(func), .alu_zero(zero),
    .mem_ready(1'b0), .pc_wr(z_pc_wr), .pc_src(z_pc_src), .ir_wr(z_ir_wr),
    .i_or_d(z_i_or_d), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .reg_wr(z_reg_wr),
    .reg_dst(z_reg_dst), .mem_to_reg(z_mem_to_reg), .ext_op(z_ext_op),
    .alu_src_a(z_alu_src_a), .alu_src_b(z_alu_src_b), .alu_ctr(z_alu_ctr),
    .state(z_state), .instr_done(z_instr_done), .illegal(z_illegal), .retired_cnt(z_cnt)
  );

  logic [18:0] m_ctl, z_ctl;
  assign m_ctl = {m_pc_wr, m_pc_src, m_ir_wr, m_i_or_d, m_mem_rd, m_mem_wr, m_reg_wr, m_reg_dst,
                  m_mem_to_reg, m_ext_op, m_alu_src_a, m_alu_src_b, m_alu_ctr, m_instr_done, m_illegal};
  assign z_ctl = {z_pc_wr, z_pc_src, z_ir_wr, z_i_or_d, z_mem_rd, z_mem_wr, z_reg_wr, z_reg_dst,
                  z_mem_to_reg, z_ext_op, z_alu_src_a, z_alu_src_b, z_alu_ctr, z_instr_done, z_illegal};

  // Control vector: pc_wr pc_src ir_wr i_or_d mem_rd mem_wr reg_wr reg_dst mem_to_reg ext_op a b alu done illegal
  localparam logic [18:0] F_OK   = 19'b1_00_1_0_1_0_0_0_0_0_0_01_000_0_0;
  localparam logic [18:0] F_ST   = 19'b0_00_0_0_1_0_0_0_0_0_0_01_000_0_0;
  localparam logic [18:0] D_GO   = 19'b0_00_0_0_0_0_0_0_0_0_0_11_000_0_0;
  localparam logic [18:0] D_NOP  = 19'b0_00_0_0_0_0_0_0_0_0_0_11_000_1_0;
  localparam logic [18:0] D_J    = 19'b1_10_0_0_0_0_0_0_0_0_0_11_000_1_0;
  localparam logic [18:0] E_ADD  = 19'b0_00_0_0_0_0_0_0_0_0_1_00_001_0_0;
  localparam logic [18:0] E_SUB  = 19'b0_00_0_0_0_0_0_0_0_0_1_00_101_0_0;
  localparam logic [18:0] E_SUBU = 19'b0_00_0_0_0_0_0_0_0_0_1_00_100_0_0;
  localparam logic [18:0] E_SLT  = 19'b0_00_0_0_0_0_0_0_0_0_1_00_111_0_0;
  localparam logic [18:0] E_SLTU = 19'b0_00_0_0_0_0_0_0_0_0_1_00_110_0_0;
  localparam logic [18:0] E_BADN = 19'b0_00_0_0_0_0_0_0_0_0_1_00_000_1_0;
  localparam logic [18:0] E_BADT = 19'b0_00_0_0_0_0_0_0_0_0_1_00_000_0_0;
  localparam logic [18:0] E_ORI  = 19'b0_00_0_0_0_0_0_0_0_0_1_10_010_0_0;
  localparam logic [18:0] E_IMM  = 19'b0_00_0_0_0_0_0_0_0_1_1_10_000_0_0;
  localparam logic [18:0] E_BQ1  = 19'b1_01_0_0_0_0_0_0_0_0_1_00_100_1_0;
  localparam logic [18:0] E_BQ0  = 19'b0_01_0_0_0_0_0_0_0_0_1_00_100_1_0;
  localparam logic [18:0] M_LW   = 19'b0_00_0_1_1_0_0_0_0_0_0_00_000_0_0;
  localparam logic [18:0] M_SW   = 19'b0_00_0_1_0_1_0_0_0_0_0_00_000_0_0;
  localparam logic [18:0] M_SWD  = 19'b0_00_0_1_0_1_0_0_0_0_0_00_000_1_0;
  localparam logic [18:0] W_R    = 19'b0_00_0_0_0_0_1_1_0_0_0_00_000_1_0;
  localparam logic [18:0] W_I    = 19'b0_00_0_0_0_0_1_0_0_0_0_00_000_1_0;
  localparam logic [18:0] W_LW   = 19'b0_00_0_0_0_0_1_0_1_0_0_00_000_1_0;
  localparam logic [18:0] T_ILL  = 19'b0_00_0_0_0_0_0_0_0_0_0_00_000_0_1;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;

  typedef struct packed {
    logic        which;
    logic [2:0]  st;
    logic [18:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   exp_cnt = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  // Monitor: every cycle with an expectation queued, compare the selected DUT.
  always @(negedge clk) begin
    exp_t        e;
    logic [2:0]  ast;
    logic [18:0] actl;
    logic [31:0] acnt;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.which) begin
        ast = z_state; actl = z_ctl; acnt = {30'b0, z_cnt};
      end else begin
        ast = m_state; actl = m_ctl; acnt = m_cnt;
      end
      chk_cnt++;
      if (ast === e.st && actl === e.ctl && acnt === e.cnt) begin
        pass_cnt++;
      end else begin
        $display("FAIL chk%0d dut%0d: state=%0d ctl=%b cnt=%0d, expected state=%0d ctl=%b cnt=%0d",
                 chk_cnt, e.which, ast, actl, acnt, e.st, e.ctl, e.cnt);
      end
    end
  end

  task automatic cyc(input logic w, input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic r, input logic [2:0] st, input logic [18:0] ctl);
    exp_t e;
    op = o; func = f; zero = z; rdy = r;
    e.which = w;
    e.st    = st;
    e.ctl   = ctl;
    e.cnt   = w ? 32'(exp_cnt % 4) : 32'(exp_cnt);
    q.push_back(e);
    if (ctl[1]) exp_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic r_type(input logic w, input logic [5:0] f, input logic [18:0] ectl);
    cyc(w, OP_R, f, 1'b0, 1'b1, 3'd0, F_OK);
    cyc(w, OP_R, f, 1'b0, 1'b1, 3'd1, D_GO);
    cyc(w, OP_R, f, 1'b0, 1'b1, 3'd2, ectl);
    cyc(w, OP_R, f, 1'b0, 1'b1, 3'd4, W_R);
  endtask

  // Reset asserted mid-cycle with mem_ready high: FETCH strobes visible but no PC/IR write.
  task automatic main_reset();
    rst_n   = 1'b0;
    exp_cnt = 0;
    cyc(1'b0, OP_R, 6'd0, 1'b0, 1'b1, 3'd0, F_ST);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst0_n = 1'b0;
    op = '0; func = '0; zero = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    cyc(1'b0, OP_R, 6'd0, 1'b0, 1'b1, 3'd0, F_ST);
    rst_n = 1'b1;

    r_type(1'b0, 6'b100000, E_ADD);

    cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 3'd0, F_OK);
    cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 3'd1, D_GO);
    cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 3'd2, E_IMM);
    for (int i = 0; i < 3; i++) cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b0, 3'd3, M_LW);
    cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 3'd3, M_LW);
    cyc(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 3'd4, W_LW);

    cyc(1'b0, OP_BEQ, 6'd0, 1'b1, 1'b1, 3'd0, F_OK);
    cyc(1'b0, OP_BEQ, 6'd0, 1'b1, 1'b1, 3'd1, D_GO);
    cyc(1'b0, OP_BEQ, 6'd0, 1'b1, 1'b1, 3'd2, E_BQ1);
    cyc(1'b0, OP_BEQ, 6'd0, 1'b0, 1'b1, 3'd0, F_OK);
    cyc(1'b0, OP_BEQ, 6'd0, 1'b0, 1'b1, 3'd1, D_GO);
    cyc(1'b0, OP_BEQ, 6'd0, 1'b0, 1'b1, 3'd2, E_BQ0);

    cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 3'd0, F_OK);
    cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 3'd1, D_J);

    r_type(1'b0, 6'b100010, E_SUB);
    r_type(1'b0, 6'b100011, E_SUBU);
    r_type(1'b0, 6'b101010, E_SLT);
    r_type(1'b0, 6'b101011, E_SLTU);

    cyc(1'b0, OP_ORI, 6'd0, 1'b0, 1'b1, 3'd0, F_OK);
    cyc(1'b0, OP_ORI, 6'd0, 1'b0, 1'b1, 3'd1, D_GO);
    cyc(1'b0, OP_ORI, 6'd0, 1'b0, 1'b1, 3'd2, E_ORI);
    cyc(1'b0, OP_ORI, 6'd0, 1'b0, 1'b1, 3'd4, W_I);

    cyc(1'b0, OP_ADDIU, 6'd0, 1'b0, 1'b1, 3'd0, F_OK);
    cyc(1'b0, OP_ADDIU, 6'd0, 1'b0, 1'b1, 3'd1, D_GO);
    cyc(1'b0, OP_ADDIU, 6'd0, 1'b0, 1'b1, 3'd2, E_IMM);
    cyc(1'b0, OP_ADDIU, 6'd0, 1'b0, 1'b1, 3'd4, W_I);

    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, 3'd0, F_ST);
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 3'd0, F_OK);
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 3'd1, D_GO);
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 3'd2, E_IMM);
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b0, 3'd3, M_SW);
    cyc(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, 3'd3, M_SWD);

    cyc(1'b0, OP_BAD, 6'd0, 1'b0, 1'b1, 3'd0, F_OK);
`ifdef MCTRL_ILLEGAL_TRAP_EN
    cyc(1'b0, OP_BAD, 6'd0, 1'b0, 1'b1, 3'd1, D_GO);
    for (int i = 0; i < 3; i++) cyc(1'b0, OP_BAD, 6'd0, 1'b0, 1'b1, 3'd5, T_ILL);
    main_reset();
`else
    cyc(1'b0, OP_BAD, 6'd0, 1'b0, 1'b1, 3'd1, D_NOP);
`endif

    cyc(1'b0, OP_R, 6'b000000, 1'b0, 1'b1, 3'd0, F_OK);
    cyc(1'b0, OP_R, 6'b000000, 1'b0, 1'b1, 3'd1, D_GO);
`ifdef MCTRL_ILLEGAL_TRAP_EN
    cyc(1'b0, OP_R, 6'b000000, 1'b0, 1'b1, 3'd2, E_BADT);
    for (int i = 0; i < 2; i++) cyc(1'b0, OP_R, 6'b000000, 1'b0, 1'b1, 3'd5, T_ILL);
`else
    cyc(1'b0, OP_R, 6'b000000, 1'b0, 1'b1, 3'd2, E_BADN);
`endif

    main_reset();
    cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 3'd0, F_OK);
    cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 3'd1, D_J);
    cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b0, 3'd0, F_ST);
    cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b0, 3'd0, F_ST);
    main_reset();
    cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 3'd0, F_OK);
    cyc(1'b0, OP_J, 6'd0, 1'b0, 1'b1, 3'd1, D_J);

    // Second instance: memory never stalls, 2-bit counter wraps after 4 retirements.
    rst_n   = 1'b0;
    rst0_n  = 1'b1;
    exp_cnt = 0;
    r_type(1'b1, 6'b100000, E_ADD);
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 3'd0, F_OK);
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 3'd1, D_GO);
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 3'd2, E_IMM);
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 3'd3, M_LW);
    cyc(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 3'd4, W_LW);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, OP_J, 6'd0, 1'b0, 1'b0, 3'd0, F_OK);
      cyc(1'b1, OP_J, 6'd0, 1'b0, 1'b0, 3'd1, D_J);
    end
    cyc(1'b1, OP_J, 6'd0, 1'b0, 1'b0, 3'd0, F_OK);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
